// File: rtl/intersection_light_ctrl.sv
// ---------------------------------------------------------------------------
// intersection_light_ctrl
//
// Traffic-light controller for one intersection with NUM_DIR approaches.
// Only one approach is served at a time. The controller steps through the
// approaches in round-robin order and cycles each one through
// ALL_RED -> RED_YEL -> GREEN -> YELLOW.
//
// - Each phase has its own duration timer.
// - Optional demand mode: approaches with no request are skipped, and the
//   current green is held while no other approach is waiting.
// - When disabled, the controller sits in OFF and flashes yellow on all
//   approaches.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   enable     in   1        1 = run the signal cycle, 0 = go to / stay in OFF
//   req        in   NUM_DIR  per-approach demand (level or single-cycle pulse)
//   red        out  NUM_DIR  red lamp per approach
//   yellow     out  NUM_DIR  yellow lamp per approach
//   green      out  NUM_DIR  green lamp per approach
//   state_out  out  3        OFF=0 ALL_RED=1 RED_YEL=2 GREEN=3 YELLOW=4
//   phase_out  out  IDX_W    approach owning RED_YEL/GREEN/YELLOW
//   pending    out  NUM_DIR  latched demand vector
// ---------------------------------------------------------------------------
module intersection_light_ctrl #(
    parameter int NUM_DIR   = 2,
    parameter int T_GREEN   = 8,
    parameter int T_YELLOW  = 2,
    parameter int T_RED_YEL = 1,
    parameter int T_ALL_RED = 1,
    parameter int T_FLASH   = 2,
    parameter int DEMAND    = 1,
    parameter int CNT_W     = 8,
    localparam int IDX_W    = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_DIR-1:0] req,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [2:0]         state_out,
    output logic [IDX_W-1:0]   phase_out,
    output logic [NUM_DIR-1:0] pending
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_ALL_RED = 3'd1;
    localparam logic [2:0] S_RED_YEL = 3'd2;
    localparam logic [2:0] S_GREEN   = 3'd3;
    localparam logic [2:0] S_YELLOW  = 3'd4;

    // A state of length T loads T-1 on entry and is left when the timer is 0.
    localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_RED_YEL = CNT_W'(T_RED_YEL - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(T_FLASH - 1);

    logic [2:0]         state_q,   state_d;
    logic [IDX_W-1:0]   phase_q,   phase_d;
    logic [NUM_DIR-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   timer_q,   timer_d;
    logic               flash_q,   flash_d;
    logic [NUM_DIR-1:0] red_q,     red_d;
    logic [NUM_DIR-1:0] yellow_q,  yellow_d;
    logic [NUM_DIR-1:0] green_q,   green_d;

    logic [NUM_DIR-1:0] phase_bit;
    logic [NUM_DIR-1:0] next_bit;
    logic               timer_zero;
    logic               others_pending;

    // Advance an approach index, wrapping at NUM_DIR (which need not be a
    // power of two).
    function automatic logic [IDX_W-1:0] inc_phase(input logic [IDX_W-1:0] p);
        inc_phase = (p == IDX_W'(NUM_DIR - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Pick the approach to serve next.
    // - Demand mode: scan cur+1, cur+2, ... cyclically. The current approach
    //   itself is the last candidate checked.
    // - Fixed rotation, or demand mode with nothing pending: cur+1.
    function automatic logic [IDX_W-1:0] next_phase(input logic [IDX_W-1:0]   cur,
                                                    input logic [NUM_DIR-1:0] pend);
        logic [IDX_W-1:0] cand;
        logic             found;
        cand       = cur;
        found      = 1'b0;
        next_phase = inc_phase(cur);
        for (int k = 1; k <= NUM_DIR; k++) begin
            cand = inc_phase(cand);
            if (DEMAND != 0 && !found && pend[cand]) begin
                found      = 1'b1;
                next_phase = cand;
            end
        end
    endfunction

    assign phase_bit      = NUM_DIR'(1) << phase_q;
    assign timer_zero     = (timer_q == '0);
    assign others_pending = |(pending_q & ~phase_bit);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        timer_d   = timer_q;
        flash_d   = flash_q;
        pending_d = pending_q | req;

        case (state_q)
            S_OFF: begin
                if (enable) begin
                    state_d = S_ALL_RED;
                    timer_d = LD_ALL_RED;
                    flash_d = 1'b0;
                end else if (timer_q == FLASH_LAST) begin
                    // In OFF the timer counts up and marks flash half-periods.
                    timer_d = '0;
                    flash_d = ~flash_q;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_ALL_RED: begin
                if (!timer_zero) begin
                    timer_d = timer_q - CNT_W'(1);
                end else if (enable) begin
                    state_d = S_RED_YEL;
                    phase_d = next_phase(phase_q, pending_q);
                    timer_d = LD_RED_YEL;
                end else begin
                    state_d = S_OFF;
                    timer_d = '0;
                    flash_d = 1'b0;
                end
            end
            S_RED_YEL: begin
                if (!timer_zero) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    state_d = S_GREEN;
                    timer_d = LD_GREEN;
                end
            end
            S_GREEN: begin
                // After the minimum green has run out, the timer sits at 0
                // and the leave decision is re-made every cycle.
                if (!timer_zero) begin
                    timer_d = timer_q - CNT_W'(1);
                end else if (!enable || DEMAND == 0 || others_pending) begin
                    state_d = S_YELLOW;
                    timer_d = LD_YELLOW;
                end
            end
            S_YELLOW: begin
                if (!timer_zero) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    state_d = S_ALL_RED;
                    timer_d = LD_ALL_RED;
                end
            end
            default: begin
                state_d = S_OFF;
                timer_d = '0;
                flash_d = 1'b0;
            end
        endcase

        // The served approach's demand is dropped on GREEN entry and ignored
        // during GREEN. The phase does not change in either case, so
        // phase_bit is the right mask. The clear is applied after the set
        // above, so a clear in the same cycle wins.
        if (state_q == S_GREEN || state_d == S_GREEN) begin
            pending_d = pending_d & ~phase_bit;
        end
    end

    // Lamps are decoded from the next state so they are registered and line
    // up with state_out.
    assign next_bit = NUM_DIR'(1) << phase_d;

    always_comb begin
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        case (state_d)
            S_OFF:     yellow_d = {NUM_DIR{flash_d}};
            S_ALL_RED: red_d    = '1;
            S_RED_YEL: begin
                red_d    = '1;
                yellow_d = next_bit;
            end
            S_GREEN: begin
                red_d   = ~next_bit;
                green_d = next_bit;
            end
            S_YELLOW: begin
                red_d    = ~next_bit;
                yellow_d = next_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            phase_q   <= '0;
            pending_q <= '0;
            timer_q   <= '0;
            flash_q   <= 1'b0;
            red_q     <= '0;
            yellow_q  <= '0;
            green_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            flash_q   <= flash_d;
            red_q     <= red_d;
            yellow_q  <= yellow_d;
            green_q   <= green_d;
        end
    end

    assign red       = red_q;
    assign yellow    = yellow_q;
    assign green     = green_q;
    assign state_out = state_q;
    assign phase_out = phase_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intersection_light_ctrl
//
// Drives three differently parameterised controllers from a shared clock,
// reset and enable.
//
// A behavioural model tracks, for each instance:
//   - the current light state,
//   - the served approach,
//   - the demand set,
//   - the number of cycles spent in the current state.
//
// From that it derives the expected lamps and status outputs, which are
// compared against the DUTs on every falling edge. Directed literal checks
// pin the model; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_intersection_light_ctrl;

    localparam int NI = 3;

    // Instance configurations: a = defaults, b = 4 approaches,
    // c = 3 approaches in fixed rotation with longer secondary phases.
    int cfg_n   [NI] = '{2, 4, 3};
    int cfg_dem [NI] = '{1, 1, 0};
    int cfg_tg  [NI] = '{8, 5, 8};
    int cfg_ty  [NI] = '{2, 2, 3};
    int cfg_try [NI] = '{1, 1, 2};
    int cfg_tar [NI] = '{1, 1, 2};
    int cfg_tf  [NI] = '{2, 2, 3};

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_c;

    logic [1:0] r_a, y_a, g_a, pd_a;
    logic [0:0] po_a;
    logic [2:0] so_a;
    logic [3:0] r_b, y_b, g_b, pd_b;
    logic [1:0] po_b;
    logic [2:0] so_b;
    logic [2:0] r_c, y_c, g_c, pd_c;
    logic [1:0] po_c;
    logic [2:0] so_c;

    int total = 0;
    int bad   = 0;

    intersection_light_ctrl #(
        .NUM_DIR(2), .T_GREEN(8), .T_YELLOW(2), .T_RED_YEL(1),
        .T_ALL_RED(1), .T_FLASH(2), .DEMAND(1), .CNT_W(8)
    ) u_a (
        .clk(clk), .rst(rst), .enable(enable), .req(req_a),
        .red(r_a), .yellow(y_a), .green(g_a),
        .state_out(so_a), .phase_out(po_a), .pending(pd_a)
    );

    intersection_light_ctrl #(
        .NUM_DIR(4), .T_GREEN(5), .T_YELLOW(2), .T_RED_YEL(1),
        .T_ALL_RED(1), .T_FLASH(2), .DEMAND(1), .CNT_W(8)
    ) u_b (
        .clk(clk), .rst(rst), .enable(enable), .req(req_b),
        .red(r_b), .yellow(y_b), .green(g_b),
        .state_out(so_b), .phase_out(po_b), .pending(pd_b)
    );

    intersection_light_ctrl #(
        .NUM_DIR(3), .T_GREEN(8), .T_YELLOW(3), .T_RED_YEL(2),
        .T_ALL_RED(2), .T_FLASH(3), .DEMAND(0), .CNT_W(4)
    ) u_c (
        .clk(clk), .rst(rst), .enable(enable), .req(req_c),
        .red(r_c), .yellow(y_c), .green(g_c),
        .state_out(so_c), .phase_out(po_c), .pending(pd_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_st   [NI];
    int m_ph   [NI];
    int m_pend [NI];
    int m_age  [NI];
    bit live = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_next(input int i, input int p, input int pd);
        int n = cfg_n[i];
        if (cfg_dem[i] != 0) begin
            for (int k = 1; k <= n; k++) begin
                if (pd[(p + k) % n]) return (p + k) % n;
            end
        end
        return (p + 1) % n;
    endfunction

    task automatic enter(input int i, input int s);
        m_st[i]  = s;
        m_age[i] = 0;
    endtask

    task automatic model_step(input int i, input int rq);
        int np;
        int old;
        if (rst) begin
            m_st[i]   = 0;
            m_ph[i]   = 0;
            m_pend[i] = 0;
            m_age[i]  = 0;
            return;
        end
        np  = m_pend[i] | rq;
        old = m_st[i];
        case (m_st[i])
            0: if (enable) enter(i, 1); else m_age[i]++;
            1: begin
                if (m_age[i] >= cfg_tar[i] - 1) begin
                    if (enable) begin
                        m_ph[i] = pick_next(i, m_ph[i], m_pend[i]);
                        enter(i, 2);
                    end else begin
                        enter(i, 0);
                    end
                end else m_age[i]++;
            end
            2: if (m_age[i] >= cfg_try[i] - 1) enter(i, 3); else m_age[i]++;
            3: begin
                if (m_age[i] >= cfg_tg[i] - 1 &&
                    (!enable || cfg_dem[i] == 0 || (m_pend[i] & ~(1 << m_ph[i])) != 0))
                    enter(i, 4);
                else m_age[i]++;
            end
            default: if (m_age[i] >= cfg_ty[i] - 1) enter(i, 1); else m_age[i]++;
        endcase
        if (old == 3 || m_st[i] == 3) np = np & ~(1 << m_ph[i]);
        m_pend[i] = np;
    endtask

    always @(posedge clk) begin
        model_step(0, int'(req_a));
        model_step(1, int'(req_b));
        model_step(2, int'(req_c));
        live = 1'b1;
    end

    task automatic cmp_inst(input int i, input int a_st, input int a_ph, input int a_pd,
                            input int a_r, input int a_y, input int a_g);
        int full, b, er, ey, eg;
        full = (1 << cfg_n[i]) - 1;
        b    = 1 << m_ph[i];
        er = 0; ey = 0; eg = 0;
        case (m_st[i])
            0: ey = (((m_age[i] / cfg_tf[i]) % 2) != 0) ? full : 0;
            1: er = full;
            2: begin er = full; ey = b; end
            3: begin er = full & ~b; eg = b; end
            default: begin er = full & ~b; ey = b; end
        endcase
        chk($sformatf("u%0d.state", i),   a_st, m_st[i]);
        chk($sformatf("u%0d.phase", i),   a_ph, m_ph[i]);
        chk($sformatf("u%0d.pending", i), a_pd, m_pend[i]);
        chk($sformatf("u%0d.red", i),     a_r,  er);
        chk($sformatf("u%0d.yellow", i),  a_y,  ey);
        chk($sformatf("u%0d.green", i),   a_g,  eg);
        chk($sformatf("u%0d.single_green", i), int'($countones(a_g) <= 1), 1);
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp_inst(0, int'(so_a), int'(po_a), int'(pd_a), int'(r_a), int'(y_a), int'(g_a));
            cmp_inst(1, int'(so_b), int'(po_b), int'(pd_b), int'(r_b), int'(y_b), int'(g_b));
            cmp_inst(2, int'(so_c), int'(po_c), int'(pd_c), int'(r_c), int'(y_c), int'(g_c));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        repeat (3) step();
        chk("rst.state", int'(so_a), 0);
        chk("rst.lamps", int'({r_a, y_a, g_a}), 0);
        chk("rst.pending", int'(pd_a), 0);
        rst = 1'b0;

        // Flash: yellow first lit two cycles after reset, toggling every two.
        step(); chk("flash.c1", int'(y_a), 0);
        step(); chk("flash.c2", int'(y_a), 3);
        step(); chk("flash.c3", int'(y_a), 3);
        step(); chk("flash.c4", int'(y_a), 0);

        // Start-up with no demand: ALL_RED, RED_YEL ph1, GREEN ph1 held.
        enable = 1'b1;
        step(); chk("up.allred", int'(so_a), 1); chk("up.allred_red", int'(r_a), 3);
        step(); chk("up.redyel", int'(so_a), 2); chk("up.redyel_ph", int'(po_a), 1);
        chk("up.redyel_y", int'(y_a), 2);
        step(); chk("up.green", int'(so_a), 3); chk("up.green_g", int'(g_a), 2);
        chk("up.green_r", int'(r_a), 1);
        repeat (12) step();
        chk("hold.green", int'(so_a), 3);

        // Demand pulse on approach 0 releases the held green.
        req_a = 2'b01;
        step(); req_a = '0;
        chk("pulse.state", int'(so_a), 3); chk("pulse.pending", int'(pd_a), 1);
        step(); chk("pulse.yellow", int'(so_a), 4); chk("pulse.yellow_y", int'(y_a), 2);
        step();
        step(); chk("pulse.allred", int'(so_a), 1);
        step(); chk("pulse.redyel", int'(so_a), 2); chk("pulse.redyel_ph", int'(po_a), 0);
        step(); chk("pulse.green", int'(g_a), 1); chk("pulse.cleared", int'(pd_a), 0);

        // Reset mid-GREEN, then a request on the GREEN entry cycle.
        step(); step();
        rst = 1'b1; req_a = 2'b11;
        step();
        rst = 1'b0; req_a = '0;
        chk("midrst.state", int'(so_a), 0); chk("midrst.pending", int'(pd_a), 0);
        chk("midrst.lamps", int'({r_a, y_a, g_a}), 0);
        step(); chk("midrst.allred", int'(so_a), 1);
        step(); chk("midrst.redyel", int'(so_a), 2);
        req_a = 2'b10;
        step(); req_a = '0;
        chk("entry.state", int'(so_a), 3); chk("entry.pending", int'(pd_a), 0);

        // Disable during GREEN: full green, then yellow, all-red, off.
        step(); step();
        enable = 1'b0;
        repeat (5) step(); chk("drain.green", int'(so_a), 3);
        step(); chk("drain.yellow", int'(so_a), 4);
        step(); step(); chk("drain.allred", int'(so_a), 1);
        step(); chk("drain.off", int'(so_a), 0);

        // Randomized operation.
        for (int c = 0; c < 3000; c++) begin
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) enable = 1'b1;
            end
            rst   = ($urandom_range(0, 499) == 0);
            req_a = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            req_b = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            req_c = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
